// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port.
// A watchdog forces err on a stalled strobe so a hung slave cannot lock the bus.
module wb_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 256
) (
   input  logic                        wb_clk,
   input  logic                        wb_rst,
   input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]      wbm_we_i,
   input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
   output logic [DW-1:0]               wbm_dat_o,
   output logic [NUM_MASTERS-1:0]      wbm_ack_o,
   output logic [NUM_MASTERS-1:0]      wbm_err_o,
   output logic [NUM_MASTERS-1:0]      wbm_rty_o,
   output logic [AW-1:0]               wbs_adr_o,
   output logic [DW-1:0]               wbs_dat_o,
   output logic [DW/8-1:0]             wbs_sel_o,
   output logic                        wbs_we_o,
   output logic                        wbs_cyc_o,
   output logic                        wbs_stb_o,
   output logic [2:0]                  wbs_cti_o,
   output logic [1:0]                  wbs_bte_o,
   input  logic [DW-1:0]               wbs_dat_i,
   input  logic                        wbs_ack_i,
   input  logic                        wbs_err_i,
   input  logic                        wbs_rty_i,
   output logic [NUM_MASTERS-1:0]      grant_o
);

   localparam int PW  = $clog2(NUM_MASTERS);
   localparam int SW  = DW / 8;
   localparam int WDW = $clog2(TIMEOUT);
   localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t                 state_r, state_s;
   logic [NUM_MASTERS-1:0] grant_r, grant_s;
   logic [PW-1:0]          ptr_r, ptr_s;
   logic [WDW-1:0]         wd_cnt_r;
   logic [PW-1:0]          gidx_s;
   logic [PW-1:0]          win_s;
   logic [PW-1:0]          cand_s;
   logic                   sel_cyc_s;
   logic                   sel_stb_s;
   logic                   resp_s;
   logic                   wd_fire_s;

   // Slave-side mux: one-hot AND-OR select, so an empty grant drives all zeros
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_cti_o = 3'b000;
      wbs_bte_o = 2'b00;
      wbs_we_o  = 1'b0;
      sel_cyc_s = 1'b0;
      sel_stb_s = 1'b0;
      gidx_s    = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         wbs_adr_o = wbs_adr_o | (wbm_adr_i[i*AW +: AW] & {AW{grant_r[i]}});
         wbs_dat_o = wbs_dat_o | (wbm_dat_i[i*DW +: DW] & {DW{grant_r[i]}});
         wbs_sel_o = wbs_sel_o | (wbm_sel_i[i*SW +: SW] & {SW{grant_r[i]}});
         wbs_cti_o = wbs_cti_o | (wbm_cti_i[i*3 +: 3] & {3{grant_r[i]}});
         wbs_bte_o = wbs_bte_o | (wbm_bte_i[i*2 +: 2] & {2{grant_r[i]}});
         wbs_we_o  = wbs_we_o  | (wbm_we_i[i]  & grant_r[i]);
         sel_cyc_s = sel_cyc_s | (wbm_cyc_i[i] & grant_r[i]);
         sel_stb_s = sel_stb_s | (wbm_stb_i[i] & grant_r[i]);
         gidx_s    = gidx_s    | (PW'(i) & {PW{grant_r[i]}});
      end
   end

   assign resp_s    = wbs_ack_i | wbs_err_i | wbs_rty_i;
   // A real slave response in the same cycle beats the watchdog
   assign wd_fire_s = (state_r == ST_OWN) & sel_stb_s & ~resp_s &
                      (wd_cnt_r == WDW'(TIMEOUT - 1));

   assign wbs_cyc_o = sel_cyc_s;
   assign wbs_stb_o = sel_stb_s & ~wd_fire_s;
   assign wbm_dat_o = wbs_dat_i;
   assign wbm_ack_o = grant_r & {NUM_MASTERS{wbs_ack_i}};
   assign wbm_err_o = grant_r & {NUM_MASTERS{wbs_err_i | wd_fire_s}};
   assign wbm_rty_o = grant_r & {NUM_MASTERS{wbs_rty_i}};
   assign grant_o   = grant_r;

   // Round-robin pick: scan downward so the last hit is the first requester at/after ptr
   always_comb begin
      win_s  = ptr_r;
      cand_s = ptr_r;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         cand_s = PW'((int'(ptr_r) + k) % NUM_MASTERS);
         win_s  = wbm_cyc_i[cand_s] ? cand_s : win_s;
      end
   end

   // Next-state logic: grant only changes on entry to or exit from OWN
   always_comb begin
      state_s = state_r;
      grant_s = grant_r;
      ptr_s   = ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (|wbm_cyc_i) begin
               state_s = ST_OWN;
               grant_s = ONE_HOT0 << win_s;
            end else begin
               state_s = ST_IDLE;
               grant_s = '0;
            end
         end
         ST_OWN: begin
            if (!sel_cyc_s) begin
               state_s = ST_IDLE;
               grant_s = '0;
               ptr_s   = (gidx_s == PW'(NUM_MASTERS - 1)) ? '0 : gidx_s + PW'(1);
            end else begin
               state_s = ST_OWN;
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = '0;
         end
      endcase
   end

   // Arbitration state registers
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_r <= ST_IDLE;
         grant_r <= '0;
         ptr_r   <= '0;
      end else begin
         state_r <= state_s;
         grant_r <= grant_s;
         ptr_r   <= ptr_s;
      end
   end

   // Watchdog: counts cycles a granted strobe has waited without any response
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         wd_cnt_r <= '0;
      end else if ((state_r != ST_OWN) || !sel_stb_s || resp_s || wd_fire_s) begin
         wd_cnt_r <= '0;
      end else begin
         wd_cnt_r <= wd_cnt_r + WDW'(1);
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against an owner/pointer/wait-count reference model.
module tb_wb_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic              wb_clk = 1'b0;
   logic              wb_rst;
   logic [N*AW-1:0]   wbm_adr_i;
   logic [N*DW-1:0]   wbm_dat_i;
   logic [N*SW-1:0]   wbm_sel_i;
   logic [N-1:0]      wbm_we_i;
   logic [N-1:0]      wbm_cyc_i;
   logic [N-1:0]      wbm_stb_i;
   logic [N*3-1:0]    wbm_cti_i;
   logic [N*2-1:0]    wbm_bte_i;
   logic [DW-1:0]     wbm_dat_o;
   logic [N-1:0]      wbm_ack_o;
   logic [N-1:0]      wbm_err_o;
   logic [N-1:0]      wbm_rty_o;
   logic [AW-1:0]     wbs_adr_o;
   logic [DW-1:0]     wbs_dat_o;
   logic [SW-1:0]     wbs_sel_o;
   logic              wbs_we_o;
   logic              wbs_cyc_o;
   logic              wbs_stb_o;
   logic [2:0]        wbs_cti_o;
   logic [1:0]        wbs_bte_o;
   logic [DW-1:0]     wbs_dat_i;
   logic              wbs_ack_i;
   logic              wbs_err_i;
   logic              wbs_rty_i;
   logic [N-1:0]      grant_o;

   wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
      .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
      .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
      .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
      .wbm_rty_o(wbm_rty_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
      .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
      .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
      .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
      .wbs_rty_i(wbs_rty_i), .grant_o(grant_o)
   );

   always #5 wb_clk = ~wb_clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the bus, whose turn is next, how long stb has waited
   int m_owner = -1;
   int m_ptr   = 0;
   int m_wait  = 0;
   bit s_stb, s_resp, s_tmo;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input int i, input bit cyc, input bit stb, input bit we, input logic [2:0] cti);
      wbm_cyc_i[i]          = cyc;
      wbm_stb_i[i]          = stb;
      wbm_we_i[i]           = we;
      wbm_cti_i[i*3 +: 3]   = cti;
      wbm_bte_i[i*2 +: 2]   = 2'($urandom_range(0, 3));
      wbm_adr_i[i*AW +: AW] = $urandom();
      wbm_dat_i[i*DW +: DW] = $urandom();
      wbm_sel_i[i*SW +: SW] = SW'($urandom_range(0, 15));
   endtask

   // Mid-cycle: compare every output against the model
   task automatic settle();
      logic [N-1:0] e_grant;
      bit own, ocyc;
      #7;
      if (wb_rst) begin
         m_owner = -1; m_ptr = 0; m_wait = 0;
      end
      own     = (m_owner >= 0);
      e_grant = own ? N'(1 << m_owner) : '0;
      ocyc    = own && wbm_cyc_i[m_owner];
      s_stb   = own && wbm_stb_i[m_owner];
      s_resp  = wbs_ack_i || wbs_err_i || wbs_rty_i;
      s_tmo   = s_stb && !s_resp && (m_wait == TO - 1);
      chk("grant",   64'(grant_o),   64'(e_grant));
      chk("wbs_cyc", 64'(wbs_cyc_o), 64'(ocyc));
      chk("wbs_stb", 64'(wbs_stb_o), 64'(s_stb && !s_tmo));
      chk("ack",     64'(wbm_ack_o), 64'((own && wbs_ack_i) ? e_grant : '0));
      chk("err",     64'(wbm_err_o), 64'((own && (wbs_err_i || s_tmo)) ? e_grant : '0));
      chk("rty",     64'(wbm_rty_o), 64'((own && wbs_rty_i) ? e_grant : '0));
      chk("mdat",    64'(wbm_dat_o), 64'(wbs_dat_i));
      if (own) begin
         chk("adr", 64'(wbs_adr_o), 64'(wbm_adr_i[m_owner*AW +: AW]));
         chk("sdat", 64'(wbs_dat_o), 64'(wbm_dat_i[m_owner*DW +: DW]));
         chk("sel", 64'(wbs_sel_o), 64'(wbm_sel_i[m_owner*SW +: SW]));
         chk("we",  64'(wbs_we_o),  64'(wbm_we_i[m_owner]));
         chk("cti", 64'(wbs_cti_o), 64'(wbm_cti_i[m_owner*3 +: 3]));
         chk("bte", 64'(wbs_bte_o), 64'(wbm_bte_i[m_owner*2 +: 2]));
      end
   endtask

   // Clock edge: advance the model, then return just after the edge
   task automatic adv();
      @(posedge wb_clk);
      if (wb_rst) begin
         m_owner = -1; m_ptr = 0; m_wait = 0;
      end else begin
         m_wait = (s_stb && !s_resp && !s_tmo) ? m_wait + 1 : 0;
         if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (m_owner < 0 && wbm_cyc_i[c]) m_owner = c;
            end
         end else if (!wbm_cyc_i[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
      #1;
   endtask

   task automatic step();
      settle();
      adv();
   endtask

   initial begin
      logic [1:0] e2;
      wb_rst = 1'b1;
      wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = '0;
      wbm_cyc_i = '0; wbm_stb_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
      wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
      #1;
      settle();
      chk("rst_grant", 64'(grant_o), 64'(2'b00));
      chk("rst_cyc",   64'(wbs_cyc_o), 64'(1'b0));
      chk("rst_stb",   64'(wbs_stb_o), 64'(1'b0));
      chk("rst_we",    64'(wbs_we_o), 64'(1'b0));
      chk("rst_resp",  64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'(6'b000000));
      adv();
      wb_rst = 1'b0;
      step();

      // 1: M0 single read
      set_m(0, 1'b1, 1'b1, 1'b0, 3'b000);
      settle(); chk("t1_cyc_lat0", 64'(wbs_cyc_o), 64'(1'b0)); adv();
      settle(); chk("t1_cyc_lat1", 64'(wbs_cyc_o), 64'(1'b1));
      chk("t1_grant", 64'(grant_o), 64'(2'b01)); adv();
      wbs_ack_i = 1'b1; wbs_dat_i = 32'hCAFE_0001;
      settle(); chk("t1_ack", 64'(wbm_ack_o), 64'(2'b01));
      chk("t1_dat", 64'(wbm_dat_o), 64'(32'hCAFE_0001)); adv();
      wbs_ack_i = 1'b0;
      set_m(0, 1'b0, 1'b0, 1'b0, 3'b000);
      step();

      // 2: simultaneous requests after reset
      wb_rst = 1'b1; step(); wb_rst = 1'b0;
      set_m(0, 1'b1, 1'b1, 1'b0, 3'b000);
      set_m(1, 1'b1, 1'b1, 1'b1, 3'b000);
      step();
      settle(); chk("t2_first", 64'(grant_o), 64'(2'b01)); adv();
      set_m(0, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      settle(); chk("t2_dead", 64'(grant_o), 64'(2'b00)); adv();
      settle(); chk("t2_second", 64'(grant_o), 64'(2'b10)); adv();

      // 3: alternation when both keep re-requesting
      set_m(1, 1'b0, 1'b0, 1'b0, 3'b000);
      set_m(0, 1'b1, 1'b1, 1'b0, 3'b000);
      step();
      for (int r = 0; r < 10; r++) begin
         e2 = (r % 2 == 0) ? 2'b01 : 2'b10;
         set_m(0, 1'b1, 1'b1, 1'b0, 3'b000);
         set_m(1, 1'b1, 1'b1, 1'b0, 3'b000);
         step();
         settle(); chk("t3_alt", 64'(grant_o), 64'(e2)); adv();
         set_m(r % 2, 1'b0, 1'b0, 1'b0, 3'b000);
         step();
      end
      set_m(0, 1'b0, 1'b0, 1'b0, 3'b000);
      set_m(1, 1'b0, 1'b0, 1'b0, 3'b000);
      step(); step();

      // 4: silent slave -> watchdog err 16 cycles after stb
      wb_rst = 1'b1; step(); wb_rst = 1'b0;
      set_m(0, 1'b1, 1'b1, 1'b0, 3'b000);
      for (int k = 0; k < 18; k++) begin
         settle();
         chk("t4_err", 64'(wbm_err_o), 64'((k == 16) ? 2'b01 : 2'b00));
         chk("t4_stb", 64'(wbs_stb_o), 64'(k >= 1 && k != 16));
         adv();
      end
      set_m(0, 1'b0, 1'b0, 1'b0, 3'b000);
      step();

      // 5: reset in the middle of an M1 burst
      wb_rst = 1'b1; step(); wb_rst = 1'b0;
      set_m(1, 1'b1, 1'b1, 1'b0, 3'b010);
      step();
      wbs_ack_i = 1'b1;
      for (int b = 0; b < 3; b++) step();
      wb_rst = 1'b1;
      settle();
      chk("t5_cyc", 64'(wbs_cyc_o), 64'(1'b0));
      chk("t5_grant", 64'(grant_o), 64'(2'b00));
      chk("t5_ack", 64'(wbm_ack_o), 64'(2'b00));
      adv();
      wb_rst = 1'b0; wbs_ack_i = 1'b0;
      set_m(0, 1'b1, 1'b1, 1'b0, 3'b000);
      step();
      settle(); chk("t5_restart", 64'(grant_o), 64'(2'b01)); adv();

      // 6: M0 4-beat burst while M1 waits
      wbs_ack_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
         set_m(0, 1'b1, 1'b1, 1'b1, (b == 3) ? 3'b111 : 3'b010);
         settle();
         chk("t6_ack", 64'(wbm_ack_o), 64'(2'b01));
         chk("t6_ack1", 64'(wbm_ack_o[1]), 64'(1'b0));
         adv();
      end
      wbs_ack_i = 1'b0;
      set_m(0, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      wbs_ack_i = 1'b1;
      settle(); chk("t6_dead_ack", 64'(wbm_ack_o), 64'(2'b00)); adv();
      settle(); chk("t6_m1_ack", 64'(wbm_ack_o), 64'(2'b10)); adv();
      wbs_ack_i = 1'b0;

      // Random traffic; every fourth 64-cycle window has a silent slave
      for (int c = 0; c < 3000; c++) begin
         bit quiet;
         quiet = ((c / 64) % 4) == 3;
         for (int i = 0; i < N; i++) begin
            bit nc;
            nc = wbm_cyc_i[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            set_m(i, nc, nc && ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)));
         end
         wbs_ack_i = !quiet && ($urandom_range(0, 1) == 1);
         wbs_err_i = !quiet && ($urandom_range(0, 15) == 0);
         wbs_rty_i = !quiet && ($urandom_range(0, 15) == 0);
         wbs_dat_i = $urandom();
         wb_rst    = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
